bnn_conv_stream: RTL and testbench

- Parametrised streaming binary-weight KxK convolution engine; next generation of the fixed 5x5, two-mode conv_mix.
- Accepts a raster-order signed pixel stream of runtime-selectable square width and applies a serially loaded ±1 kernel, emitting valid-only ("valid" padding) results.
- Adds over conv_mix: input valid handshake with stalls, runtime image width, output saturation, busy and weight-loaded status.
- Sits between the image/feature-map source and the pooling/binarisation stage.

---
 rtl/bnn_conv_stream.sv | 187 ++++++++++++++++++
 tb/tb_bnn_conv_stream.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_conv_stream.sv
// Streaming KxK binary-weight (+1/-1) convolution over a raster pixel stream.
// Uses valid padding, supports input stalls and saturates the output.
module bnn_conv_stream #(
  parameter int DATA_W = 16,
  parameter int K      = 5,
  parameter int MAX_W  = 28,
  parameter int IW_W   = 6
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [IW_W-1:0]          img_w,
  input  logic                     weight_en,
  input  logic                     weight,
  input  logic                     din_valid,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     ovalid,
  output logic                     done,
  output logic                     busy,
  output logic                     wload_done
);
  localparam int KK    = K * K;
  localparam int WC_W  = $clog2(KK);
  localparam int ACC_W = DATA_W + $clog2(KK) + 1;
  localparam int LB_AW = $clog2(MAX_W);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [IW_W-1:0] KM1 = IW_W'(K - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [0:0]               state_q, state_d;
  logic [IW_W-1:0]          imgw_q, imgw_d, row_q, row_d, col_q, col_d;
  logic                     fin_q, fin_d;
  logic [KK-1:0]            w_q, w_d;
  logic [WC_W-1:0]          wcnt_q, wcnt_d;
  logic                     wdone_q, wdone_d;
  logic [2:0]               vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic signed [DATA_W-1:0] win_q [K][K];
  logic signed [DATA_W-1:0] win_d [K][K];
  logic signed [DATA_W:0]   term_q [KK];
  logic signed [DATA_W:0]   term_d [KK];
  logic signed [DATA_W-1:0] lb_q [K-1][MAX_W];
  logic signed [DATA_W-1:0] tap [K];
  logic signed [DATA_W:0]   px;
  logic signed [ACC_W-1:0]  sum;
  logic [IW_W-1:0]          imgw_m1;
  logic [LB_AW-1:0]         cidx;
  logic                     accept, in_win, last_px;

  // fin_q blocks extra pixels between the last accepted pixel and IDLE
  assign accept  = (state_q == S_RUN) && din_valid && !fin_q;
  assign imgw_m1 = imgw_q - IW_W'(1);
  assign in_win  = (row_q >= KM1) && (col_q >= KM1);
  assign last_px = (row_q == imgw_m1) && (col_q == imgw_m1);
  assign cidx    = col_q[LB_AW-1:0];

  // Column entering the window: tap[K-1] is the current row, tap[0] the oldest.
  always_comb begin
    tap[K-1] = din;
    for (int m = 1; m < K; m++) tap[K-1-m] = lb_q[m-1][cidx];
  end

  always_comb begin
    state_d = state_q;
    imgw_d  = imgw_q;
    row_d   = row_q;
    col_d   = col_q;
    fin_d   = fin_q;
    w_d     = w_q;
    wcnt_d  = wcnt_q;
    wdone_d = wdone_q;
    if (state_q == S_IDLE) begin
      if (weight_en) begin
        if (wdone_q) begin
          w_d[0]  = weight;
          wcnt_d  = WC_W'(1);
          wdone_d = 1'b0;
        end else begin
          w_d[wcnt_q] = weight;
          if (wcnt_q == WC_W'(KK - 1)) begin
            wcnt_d  = '0;
            wdone_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
      end
      if (start && (img_w >= IW_W'(K)) && (img_w <= IW_W'(MAX_W))) begin
        state_d = S_RUN;
        imgw_d  = img_w;
        row_d   = '0;
        col_d   = '0;
        fin_d   = 1'b0;
      end
    end else begin
      if (accept) begin
        if (col_q == imgw_m1) begin
          col_d = '0;
          row_d = row_q + IW_W'(1);
        end else begin
          col_d = col_q + IW_W'(1);
        end
        if (last_px) fin_d = 1'b1;
      end
      if (last_pipe_q[2]) state_d = S_IDLE;
    end
  end

  always_comb begin
    win_d  = win_q;
    term_d = term_q;
    dout_d = dout_q;
    px     = '0;
    sum    = '0;
    if (accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win_d[i][j] = win_q[i][j+1];
        win_d[i][K-1] = tap[i];
      end
    end
    if (vld_pipe_q[0]) begin
      for (int n = 0; n < KK; n++) begin
        px        = {win_q[n / K][n % K][DATA_W-1], win_q[n / K][n % K]};
        term_d[n] = w_q[n] ? px : -px;
      end
    end
    for (int n = 0; n < KK; n++) sum = sum + ACC_W'(term_q[n]);
    if (vld_pipe_q[1]) begin
      if (sum > SAT_MAX)      dout_d = SAT_MAX[DATA_W-1:0];
      else if (sum < SAT_MIN) dout_d = SAT_MIN[DATA_W-1:0];
      else                    dout_d = sum[DATA_W-1:0];
    end
    vld_pipe_d  = {vld_pipe_q[1:0], accept && in_win};
    last_pipe_d = {last_pipe_q[1:0], accept && last_px};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      imgw_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      fin_q       <= 1'b0;
      w_q         <= '0;
      wcnt_q      <= '0;
      wdone_q     <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      imgw_q      <= imgw_d;
      row_q       <= row_d;
      col_q       <= col_d;
      fin_q       <= fin_d;
      w_q         <= w_d;
      wcnt_q      <= wcnt_d;
      wdone_q     <= wdone_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      dout_q      <= dout_d;
    end
  end

  // Window, term and line-buffer storage need no reset: only flagged data is used.
  always_ff @(posedge clk) begin
    win_q  <= win_d;
    term_q <= term_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][cidx] <= din;
      for (int m = 1; m < K - 1; m++) lb_q[m][cidx] <= lb_q[m-1][cidx];
    end
  end

  assign dout       = dout_q;
  assign ovalid     = vld_pipe_q[2];
  assign done       = last_pipe_q[2];
  assign busy       = (state_q == S_RUN);
  assign wload_done = wdone_q;

endmodule

// File: tb/tb_bnn_conv_stream.sv
// Bench for bnn_conv_stream: a frame-level reference model predicts each result
// and its cycle; a monitor compares outputs and status on every cycle.
module tb_bnn_conv_stream;
  localparam int DATA_W = 16;
  localparam int K      = 5;
  localparam int MAX_W  = 28;
  localparam int IW_W   = 6;
  localparam int KK     = K * K;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, weight_en = 1'b0, weight = 1'b0, din_valid = 1'b0;
  logic [IW_W-1:0] img_w = '0;
  logic signed [DATA_W-1:0] din = '0;
  logic signed [DATA_W-1:0] dout;
  logic ovalid, done, busy, wload_done;

  bnn_conv_stream #(.DATA_W(DATA_W), .K(K), .MAX_W(MAX_W), .IW_W(IW_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .img_w(img_w), .weight_en(weight_en),
    .weight(weight), .din_valid(din_valid), .din(din), .dout(dout), .ovalid(ovalid),
    .done(done), .busy(busy), .wload_done(wload_done)
  );

  always #5 clk = ~clk;

  typedef struct { longint val; int due; bit last; } exp_t;
  exp_t q[$];
  int nvec = 0, nmis = 0, cyc = 0;
  bit chk_en = 1'b0;
  bit m_run = 1'b0, m_wdone = 1'b0;
  bit mw [KK];
  int m_wcnt = 0, m_w = 0, m_p = 0, m_end = -1;
  longint m_dout = 0;
  longint img [MAX_W*MAX_W];
  int n_out = 0;
  longint first_val = 0;
  logic [KK-1:0] ones = '1;
  logic [KK-1:0] rw;

  task automatic chk(string nm, logic signed [63:0] act, longint exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: direct +/- sum over the stored frame, then clamp.
  function automatic longint win_res(int r, int c);
    longint s, hi, lo, v;
    s = 0;
    hi = (64'sd1 <<< (DATA_W - 1)) - 1;
    lo = -(64'sd1 <<< (DATA_W - 1));
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        v = img[(r - K + 1 + i) * m_w + (c - K + 1 + j)];
        s += mw[i*K + j] ? v : -v;
      end
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      m_run = 0; m_wdone = 0; m_wcnt = 0; m_end = -1; m_dout = 0;
      foreach (mw[n]) mw[n] = 0;
      q.delete();
    end else if (m_run) begin
      if (cyc == m_end) m_run = 0;
      else if (din_valid && m_p < m_w * m_w) begin
        int r, c;
        exp_t e;
        r = m_p / m_w;
        c = m_p % m_w;
        img[m_p] = din;
        if (r >= K - 1 && c >= K - 1) begin
          e.val = win_res(r, c);
          e.due = cyc + 2;
          e.last = (m_p == m_w * m_w - 1);
          q.push_back(e);
          if (e.last) m_end = cyc + 3;
        end
        m_p++;
      end
    end else begin
      if (weight_en) begin
        if (m_wdone) begin m_wdone = 0; m_wcnt = 0; end
        mw[m_wcnt] = weight;
        m_wcnt++;
        if (m_wcnt == KK) begin m_wdone = 1; m_wcnt = 0; end
      end
      if (start && int'(img_w) >= K && int'(img_w) <= MAX_W) begin
        m_run = 1; m_w = int'(img_w); m_p = 0; m_end = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("ovalid", ovalid, ev);
      if (ev) begin
        chk("dout", $signed(dout), q[0].val);
        chk("done", done, q[0].last);
        m_dout = q[0].val;
        if (n_out == 0) first_val = $signed(dout);
        n_out++;
        void'(q.pop_front());
      end else begin
        chk("dout_hold", $signed(dout), m_dout);
        chk("done_idle", done, 0);
      end
      chk("busy", busy, m_run);
      chk("wload_done", wload_done, m_wdone);
    end
  end

  task automatic load(logic [KK-1:0] bits, int from);
    for (int n = from; n < KK; n++) begin
      weight_en = 1; weight = bits[n];
      @(negedge clk);
    end
    weight_en = 0;
  endtask

  function automatic logic [DATA_W-1:0] pix(int mode, int p, longint pval);
    case (mode)
      0:       return DATA_W'(pval);
      1:       return DATA_W'(p);
      default: return DATA_W'($urandom);
    endcase
  endfunction

  // smode: 0 no stalls, 1 alternate valid/invalid, 2 random stalls.
  // noise toggles weight_en and start while the frame runs.
  task automatic feed(int w, int pmode, longint pval, int smode, bit noise, int rst_at);
    for (int p = 0; p < w * w; p++) begin
      if (p == rst_at) begin
        din_valid = 0; rstn = 0;
        @(negedge clk);
        rstn = 1;
        return;
      end
      if (smode == 1 && p > 0) begin
        din_valid = 0; din = DATA_W'($urandom);
        @(negedge clk);
      end else if (smode == 2) begin
        while ($urandom_range(0, 3) == 0) begin
          din_valid = 0; din = DATA_W'($urandom);
          @(negedge clk);
        end
      end
      din_valid = 1; din = pix(pmode, p, pval);
      if (noise) begin
        weight_en = 1'($urandom); weight = 1'($urandom);
        start = ($urandom_range(0, 15) == 0); img_w = IW_W'(8);
      end
      @(negedge clk);
    end
    din_valid = 0; weight_en = 0; start = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("idle_timeout", busy, 0);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic begin_frame(int w);
    n_out = 0; first_val = -999999;
    start = 1; img_w = IW_W'(w);
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_frame(int w, int pmode, longint pval, int smode, bit noise);
    begin_frame(w);
    feed(w, pmode, pval, smode, noise, -1);
    wait_idle();
  endtask

  task automatic try_reject(int w);
    n_out = 0;
    start = 1; img_w = IW_W'(w);
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 6; i++) begin
      din_valid = 1; din = DATA_W'($urandom);
      @(negedge clk);
    end
    din_valid = 0;
    chk("reject_busy", busy, 0);
    chk("reject_nout", n_out, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_dout", $signed(dout), 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wload", wload_done, 0);
    rstn = 1;
    @(negedge clk);

    // all +1 weights, constant 1 pixels, full width
    load(ones, 0);
    chk("wl_full", wload_done, 1);
    run_frame(28, 0, 1, 0, 0);
    chk("t1_count", n_out, 576);
    chk("t1_first", first_val, 25);

    // all -1 weights, reused across two frames
    load('0, 0);
    run_frame(12, 0, 1, 0, 0);
    chk("t2_count", n_out, 64);
    chk("t2_first", first_val, -25);
    run_frame(12, 0, 1, 0, 0);
    chk("t2_again_count", n_out, 64);
    chk("t2_again_first", first_val, -25);

    // only top-left +1, raster-index pixels, then alternating stalls
    load(KK'(1), 0);
    run_frame(8, 1, 0, 0, 0);
    chk("t3_count", n_out, 16);
    chk("t3_first", first_val, -450);
    run_frame(8, 1, 0, 1, 0);
    chk("t3_stall_count", n_out, 16);
    chk("t3_stall_first", first_val, -450);

    // saturation both ways
    load(ones, 0);
    run_frame(8, 0, 32767, 0, 0);
    chk("sat_hi", first_val, 32767);
    run_frame(8, 0, -32768, 0, 0);
    chk("sat_lo", first_val, -32768);

    // rejected starts, weight reload restart, noise during RUN
    try_reject(4);
    try_reject(29);
    rw = KK'($urandom);
    load(rw, 0);
    weight_en = 1; weight = 1;
    @(negedge clk);
    weight_en = 0;
    chk("wl_restart", wload_done, 0);
    load(KK'($urandom), 1);
    chk("wl_reloaded", wload_done, 1);
    run_frame(10, 2, 0, 2, 1);
    chk("noise_count", n_out, 36);

    // mid-frame reset then a clean frame
    load(ones, 0);
    begin_frame(28);
    feed(28, 2, 0, 0, 0, 300);
    chk("mrst_dout", $signed(dout), 0);
    chk("mrst_ovalid", ovalid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_wload", wload_done, 0);
    load(KK'($urandom), 0);
    run_frame(28, 2, 0, 2, 0);
    chk("post_rst_count", n_out, 576);

    // random widths, weights, pixels and stalls
    for (int t = 0; t < 3; t++) begin
      int w;
      w = $urandom_range(K, MAX_W);
      load(KK'($urandom), 0);
      run_frame(w, 2, 0, 2, 1'($urandom));
      chk("rand_count", n_out, (w - K + 1) * (w - K + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
